// File: rtl/clks_alot_p.sv
// Types and constants for the clocks-alot recovery and generation path.
//   RATE_COUNTER_WIDTH : width of every rate counter / half-rate register.
//   clock_state_s      : filtered clock level plus single-cycle edge pulses.
//   recovery_state_e   : recovery FSM states.
//   sat_inc            : saturating increment of a rate counter.
package clks_alot_p;

  localparam int unsigned RATE_COUNTER_WIDTH = 8;

  typedef logic [RATE_COUNTER_WIDTH-1:0] rate_t;

  typedef struct packed {
    logic clk;
    logic rise;
    logic fall;
    logic any_edge;
  } clock_state_s;

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    MEASURING,
    TRACKING
  } recovery_state_e;

  function automatic rate_t sat_inc(input rate_t v);
    return (v == '1) ? v : v + rate_t'(1);
  endfunction

endpackage

// File: rtl/common_p.sv
// Shared clock-domain bundle used across the codebase.
//   clk_dom_s : single system clock plus its asynchronous active-low reset.
package common_p;

  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom_s;

endpackage

// File: rtl/pin_synchroniser.sv
// Multi-flop synchroniser for a raw asynchronous pin, plus a one-cycle delayed copy of the
// synchronised level so callers can detect raw edges.
//   sys_dom_i   : system clock and asynchronous active-low reset
//   pin_i       : raw asynchronous input
//   sync_o      : synchronised level (last flop of the chain)
//   sync_prev_o : sync_o delayed by one cycle
// SYNC_STAGES must be 2 to 4.
module pin_synchroniser
  import common_p::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  clk_dom_s sys_dom_i,
  input  logic     pin_i,
  output logic     sync_o,
  output logic     sync_prev_o
);

  logic clk;
  logic rst_n;
  assign clk   = sys_dom_i.clk;
  assign rst_n = sys_dom_i.rst_n;

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], pin_i};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync_o      = chain_q[SYNC_STAGES-1];
  assign sync_prev_o = prev_q;

endmodule

// File: rtl/clock_recovery.sv
// Receive-side front end of the clocks-alot recovery path. Synchronises the incoming clock pin,
// rejects edges that arrive sooner than min_half_rate_i, emits rise/fall events and measures the
// high and low half-rates with a saturating accumulator.
//   sys_dom_i           : system clock and asynchronous active-low reset
//   recovery_en_i       : enable; low forces IDLE and clears everything
//   clear_state_i       : synchronous re-arm
//   clk_pin_i           : raw asynchronous incoming clock
//   starting_polarity_i : level that starts a cycle (1 = rise, 0 = fall)
//   min_half_rate_i     : minimum legal half-rate in sys cycles
//   timeout_i           : stall threshold in sys cycles, 0 disables
//   actual_clk_state_o  : filtered level plus rise/fall/any_edge pulses
//   polarity_event_o    : accepted edge whose new level equals starting_polarity_i
//   rate_accumulator_o  : cycles since the last accepted edge
//   high_half_rate_o    : last measured high duration
//   low_half_rate_o     : last measured low duration
//   rates_valid_o       : both half-rates measured since arming
//   glitch_o            : pulse when a raw edge is rejected
//   stall_o             : pulse when the timeout fires
module clock_recovery
  import common_p::*;
  import clks_alot_p::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  clk_dom_s                      sys_dom_i,
  input  logic                          recovery_en_i,
  input  logic                          clear_state_i,
  input  logic                          clk_pin_i,
  input  logic                          starting_polarity_i,
  input  logic [RATE_COUNTER_WIDTH-1:0] min_half_rate_i,
  input  logic [RATE_COUNTER_WIDTH-1:0] timeout_i,
  output clock_state_s                  actual_clk_state_o,
  output logic                          polarity_event_o,
  output logic [RATE_COUNTER_WIDTH-1:0] rate_accumulator_o,
  output logic [RATE_COUNTER_WIDTH-1:0] high_half_rate_o,
  output logic [RATE_COUNTER_WIDTH-1:0] low_half_rate_o,
  output logic                          rates_valid_o,
  output logic                          glitch_o,
  output logic                          stall_o
);

  logic clk;
  logic rst_n;
  assign clk   = sys_dom_i.clk;
  assign rst_n = sys_dom_i.rst_n;

  logic sync_q;
  logic sync_prev;

  pin_synchroniser #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync (
    .sys_dom_i  (sys_dom_i),
    .pin_i      (clk_pin_i),
    .sync_o     (sync_q),
    .sync_prev_o(sync_prev)
  );

  recovery_state_e state_q;
  logic            filt_q;
  logic            rise_q;
  logic            fall_q;
  logic            pol_q;
  logic            glitch_q;
  logic            stall_q;
  logic            valid_q;
  logic            have_high_q;
  logic            have_low_q;
  rate_t           acc_q;
  rate_t           high_q;
  rate_t           low_q;

  rate_t acc_inc;
  logic  raw_edge;
  logic  mismatch;
  logic  thresh_met;
  logic  accept;
  logic  glitch;
  logic  timeout_hit;
  logic  new_pol;

  always_comb begin
    acc_inc     = sat_inc(acc_q);
    raw_edge    = sync_q != sync_prev;
    mismatch    = sync_q != filt_q;
    thresh_met  = acc_inc >= min_half_rate_i;
    accept      = mismatch && thresh_met;
    // Only the edge that leaves the filtered level counts; its return is not a second glitch.
    glitch      = raw_edge && mismatch && !thresh_met;
    timeout_hit = ((state_q == MEASURING) || (state_q == TRACKING)) &&
                  (timeout_i != '0) && (acc_inc >= timeout_i);
    new_pol     = sync_q == starting_polarity_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      filt_q      <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      pol_q       <= 1'b0;
      glitch_q    <= 1'b0;
      stall_q     <= 1'b0;
      valid_q     <= 1'b0;
      have_high_q <= 1'b0;
      have_low_q  <= 1'b0;
      acc_q       <= '0;
      high_q      <= '0;
      low_q       <= '0;
    end else begin
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      pol_q    <= 1'b0;
      glitch_q <= 1'b0;
      stall_q  <= 1'b0;
      if (!recovery_en_i) begin
        state_q     <= IDLE;
        filt_q      <= 1'b0;
        valid_q     <= 1'b0;
        have_high_q <= 1'b0;
        have_low_q  <= 1'b0;
        acc_q       <= '0;
        high_q      <= '0;
        low_q       <= '0;
      end else if ((state_q == IDLE) || clear_state_i) begin
        // Arm on the current pin level so enabling never produces a spurious edge.
        state_q     <= ARMING;
        filt_q      <= sync_q;
        valid_q     <= 1'b0;
        have_high_q <= 1'b0;
        have_low_q  <= 1'b0;
        acc_q       <= '0;
        high_q      <= '0;
        low_q       <= '0;
      end else begin
        glitch_q <= glitch;
        if (accept) begin
          filt_q <= sync_q;
          acc_q  <= '0;
          rise_q <= sync_q;
          fall_q <= !sync_q;
          pol_q  <= new_pol;
          case (state_q)
            ARMING: begin
              if (new_pol) state_q <= MEASURING;
            end
            MEASURING, TRACKING: begin
              // A rise closes a low phase, a fall closes a high phase.
              if (sync_q) begin
                low_q      <= acc_inc;
                have_low_q <= 1'b1;
              end else begin
                high_q      <= acc_inc;
                have_high_q <= 1'b1;
              end
              if ((sync_q || have_low_q) && (!sync_q || have_high_q)) begin
                state_q <= TRACKING;
                valid_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end else if (timeout_hit) begin
          stall_q     <= 1'b1;
          state_q     <= ARMING;
          valid_q     <= 1'b0;
          have_high_q <= 1'b0;
          have_low_q  <= 1'b0;
          acc_q       <= '0;
          high_q      <= '0;
          low_q       <= '0;
        end else begin
          acc_q <= acc_inc;
        end
      end
    end
  end

  assign actual_clk_state_o = '{clk: filt_q, rise: rise_q, fall: fall_q,
                                any_edge: rise_q | fall_q};
  assign polarity_event_o   = pol_q;
  assign rate_accumulator_o = acc_q;
  assign high_half_rate_o   = high_q;
  assign low_half_rate_o    = low_q;
  assign rates_valid_o      = valid_q;
  assign glitch_o           = glitch_q;
  assign stall_o            = stall_q;

endmodule

// File: tb/tb_clock_recovery.sv
// Directed bench for clock_recovery. Inputs change on the falling clock edge; outputs are
// sampled on the falling edge just before new inputs are driven, so a pin change at sample
// index i produces its event at index i+3 with SYNC_STAGES=2.
module tb_clock_recovery;
  import common_p::*;
  import clks_alot_p::*;

  localparam int W = RATE_COUNTER_WIDTH;
  localparam int N = 320;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  clk_dom_s sys_dom;
  assign sys_dom = '{clk: clk, rst_n: rst_n};
  always #5 clk = ~clk;

  logic         en = 1'b0;
  logic         clr = 1'b0;
  logic         pin = 1'b0;
  logic         spol = 1'b0;
  logic [W-1:0] min_hr = 8'd1;
  logic [W-1:0] tmo = 8'd0;
  clock_state_s cs;
  logic         pol, valid, glitch, stall;
  logic [W-1:0] acc, high, low;

  clock_recovery #(
    .SYNC_STAGES(2)
  ) dut (
    .sys_dom_i          (sys_dom),
    .recovery_en_i      (en),
    .clear_state_i      (clr),
    .clk_pin_i          (pin),
    .starting_polarity_i(spol),
    .min_half_rate_i    (min_hr),
    .timeout_i          (tmo),
    .actual_clk_state_o (cs),
    .polarity_event_o   (pol),
    .rate_accumulator_o (acc),
    .high_half_rate_o   (high),
    .low_half_rate_o    (low),
    .rates_valid_o      (valid),
    .glitch_o           (glitch),
    .stall_o            (stall)
  );

  int errors = 0;
  int checks = 0;

  logic         pin_vec [0:N-1];
  logic         clr_vec [0:N-1];
  logic         s_clk [0:N-1];
  logic         s_rise [0:N-1];
  logic         s_fall [0:N-1];
  logic         s_any [0:N-1];
  logic         s_pol [0:N-1];
  logic         s_glitch [0:N-1];
  logic         s_stall [0:N-1];
  logic         s_valid [0:N-1];
  logic [W-1:0] s_acc [0:N-1];
  logic [W-1:0] s_high [0:N-1];
  logic [W-1:0] s_low [0:N-1];

  task automatic set_pins(input logic lvl, input int from, input int to);
    for (int k = from; k < to; k++) pin_vec[k] = lvl;
  endtask

  task automatic clear_vecs();
    for (int k = 0; k < N; k++) begin
      pin_vec[k] = 1'b0;
      clr_vec[k] = 1'b0;
    end
  endtask

  // Sample outputs, then drive the next pin/clear values, once per cycle.
  task automatic run_vec(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_clk[i] = cs.clk;       s_rise[i] = cs.rise;     s_fall[i] = cs.fall;
      s_any[i] = cs.any_edge;  s_pol[i] = pol;          s_glitch[i] = glitch;
      s_stall[i] = stall;      s_valid[i] = valid;      s_acc[i] = acc;
      s_high[i] = high;        s_low[i] = low;
      pin = pin_vec[i];
      clr = clr_vec[i];
    end
  endtask

  task automatic test_reset();
    logic seen;
    repeat (3) @(negedge clk);
    checks++; if ({cs, pol, valid, glitch, stall} !== 8'h00) begin errors++;
      $display("FAIL reset_flags got=%b exp=0", {cs, pol, valid, glitch, stall}); end
    checks++; if ({acc, high, low} !== 24'h0) begin errors++;
      $display("FAIL reset_rates got=%h exp=0", {acc, high, low}); end
    rst_n = 1'b1;
    seen = 1'b0;
    pin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) pin = 1'b0;
      seen = seen | cs.any_edge | cs.clk | (acc != '0);
    end
    checks++; if (seen !== 1'b0) begin errors++;
      $display("FAIL idle_quiet got=%b exp=0", seen); end
    en = 1'b1;
  endtask

  task automatic test_lock();
    clear_vecs();
    for (int p = 0; p < 3; p++) set_pins(1'b1, 4 * p, 4 * p + 2);
    run_vec(16);
    checks++; if (s_rise[2] !== 1'b0 || s_rise[3] !== 1'b1) begin errors++;
      $display("FAIL lock_latency got=%b%b exp=01", s_rise[2], s_rise[3]); end
    checks++; if (s_pol[3] !== 1'b0 || s_any[3] !== 1'b1) begin errors++;
      $display("FAIL lock_rise_flags got=%b%b exp=01", s_pol[3], s_any[3]); end
    checks++; if (s_fall[5] !== 1'b1 || s_pol[5] !== 1'b1 || s_clk[5] !== 1'b0) begin errors++;
      $display("FAIL lock_first_fall got=%b%b%b exp=110", s_fall[5], s_pol[5], s_clk[5]); end
    checks++; if (s_acc[6] !== 8'd1) begin errors++;
      $display("FAIL lock_acc got=%0d exp=1", s_acc[6]); end
    checks++; if (s_low[7] !== 8'd2 || s_valid[7] !== 1'b0 || s_clk[7] !== 1'b1) begin errors++;
      $display("FAIL lock_low got=%0d/%b exp=2/0", s_low[7], s_valid[7]); end
    checks++; if (s_high[9] !== 8'd2 || s_valid[9] !== 1'b1 || s_valid[8] !== 1'b0) begin
      errors++; $display("FAIL lock_high got=%0d/%b exp=2/1", s_high[9], s_valid[9]); end
    checks++; if (s_rise[11] !== 1'b1 || s_fall[13] !== 1'b1 || s_pol[13] !== 1'b1) begin
      errors++; $display("FAIL lock_steady got=%b%b%b exp=111", s_rise[11], s_fall[13], s_pol[13]); end
  endtask

  task automatic test_glitch();
    int gcount;
    min_hr = 8'd3;
    clear_vecs();
    set_pins(1'b1, 0, 4);
    set_pins(1'b1, 5, 6);
    set_pins(1'b1, 11, 17);
    run_vec(17);
    gcount = 0;
    for (int i = 0; i < 17; i++) gcount += int'(s_glitch[i]);
    checks++; if (s_glitch[8] !== 1'b1 || gcount != 1) begin errors++;
      $display("FAIL glitch_pulse got=%b/%0d exp=1/1", s_glitch[8], gcount); end
    checks++; if (s_any[8] !== 1'b0 || s_any[9] !== 1'b0 || s_clk[9] !== 1'b0) begin errors++;
      $display("FAIL glitch_no_event got=%b%b%b exp=000", s_any[8], s_any[9], s_clk[9]); end
    checks++; if (s_high[6] !== 8'd2 || s_high[7] !== 8'd4) begin errors++;
      $display("FAIL glitch_high got=%0d/%0d exp=2/4", s_high[6], s_high[7]); end
    checks++; if (s_low[13] !== 8'd6 || s_low[14] !== 8'd7 || s_rise[14] !== 1'b1) begin
      errors++; $display("FAIL glitch_low got=%0d/%0d exp=6/7", s_low[13], s_low[14]); end
  endtask

  task automatic test_stall();
    int scount;
    tmo = 8'd10;
    clear_vecs();
    run_vec(32);
    scount = 0;
    for (int i = 0; i < 32; i++) scount += int'(s_stall[i]);
    checks++; if (s_fall[3] !== 1'b1 || s_high[3] !== 8'd6) begin errors++;
      $display("FAIL stall_fall got=%b/%0d exp=1/6", s_fall[3], s_high[3]); end
    checks++; if (s_acc[12] !== 8'd9 || s_stall[12] !== 1'b0) begin errors++;
      $display("FAIL stall_pre got=%0d/%b exp=9/0", s_acc[12], s_stall[12]); end
    checks++; if (s_stall[13] !== 1'b1 || s_valid[13] !== 1'b0 || s_acc[13] !== 8'd0) begin
      errors++; $display("FAIL stall_fire got=%b%b/%0d exp=10/0", s_stall[13], s_valid[13],
                         s_acc[13]); end
    checks++; if (s_high[13] !== 8'd0 || s_low[13] !== 8'd0) begin errors++;
      $display("FAIL stall_clear got=%0d/%0d exp=0/0", s_high[13], s_low[13]); end
    checks++; if (scount != 1) begin errors++;
      $display("FAIL stall_arming got=%0d exp=1", scount); end
  endtask

  task automatic test_rearm();
    tmo = 8'd0;
    min_hr = 8'd1;
    clear_vecs();
    set_pins(1'b1, 0, 4);
    set_pins(1'b1, 8, 12);
    set_pins(1'b1, 16, 20);
    set_pins(1'b1, 24, 28);
    clr_vec[18] = 1'b1;
    run_vec(34);
    checks++; if (s_rise[3] !== 1'b1 || s_low[3] !== 8'd0 || s_high[7] !== 8'd0) begin
      errors++; $display("FAIL rearm_arming got=%b/%0d/%0d exp=1/0/0", s_rise[3], s_low[3],
                         s_high[7]); end
    checks++; if (s_low[11] !== 8'd4 || s_high[15] !== 8'd4 || s_valid[15] !== 1'b1) begin
      errors++; $display("FAIL rearm_lock got=%0d/%0d/%b exp=4/4/1", s_low[11], s_high[15],
                         s_valid[15]); end
    checks++; if (s_rise[19] !== 1'b0 || s_clk[19] !== 1'b1 || s_valid[19] !== 1'b0) begin
      errors++; $display("FAIL rearm_clear got=%b%b%b exp=010", s_rise[19], s_clk[19],
                         s_valid[19]); end
    checks++; if (s_low[19] !== 8'd0 || s_high[19] !== 8'd0 || s_acc[22] !== 8'd3) begin
      errors++; $display("FAIL rearm_regs got=%0d/%0d/%0d exp=0/0/3", s_low[19], s_high[19],
                         s_acc[22]); end
    checks++; if (s_fall[23] !== 1'b1 || s_pol[23] !== 1'b1 || s_valid[27] !== 1'b0) begin
      errors++; $display("FAIL rearm_restart got=%b%b%b exp=110", s_fall[23], s_pol[23],
                         s_valid[27]); end
    checks++; if (s_low[27] !== 8'd4 || s_high[31] !== 8'd4 || s_valid[31] !== 1'b1
                  || s_valid[30] !== 1'b0) begin
      errors++; $display("FAIL rearm_relock got=%0d/%0d/%b exp=4/4/1", s_low[27], s_high[31],
                         s_valid[31]); end
  endtask

  task automatic test_saturation();
    clear_vecs();
    set_pins(1'b1, 0, 300);
    run_vec(306);
    checks++; if (s_low[3] !== 8'd6 || s_high[302] !== 8'd4) begin errors++;
      $display("FAIL sat_pre got=%0d/%0d exp=6/4", s_low[3], s_high[302]); end
    checks++; if (s_acc[257] !== 8'd254 || s_acc[258] !== 8'd255) begin errors++;
      $display("FAIL sat_reach got=%0d/%0d exp=254/255", s_acc[257], s_acc[258]); end
    checks++; if (s_acc[299] !== 8'd255 || s_acc[302] !== 8'd255) begin errors++;
      $display("FAIL sat_hold got=%0d/%0d exp=255/255", s_acc[299], s_acc[302]); end
    checks++; if (s_fall[303] !== 1'b1 || s_high[303] !== 8'd255 || s_acc[303] !== 8'd0) begin
      errors++; $display("FAIL sat_capture got=%b/%0d/%0d exp=1/255/0", s_fall[303],
                         s_high[303], s_acc[303]); end
  endtask

  task automatic test_disable();
    logic seen;
    clear_vecs();
    set_pins(1'b1, 0, 5);
    run_vec(5);
    checks++; if (s_rise[3] !== 1'b1 || s_clk[4] !== 1'b1 || s_valid[4] !== 1'b1) begin
      errors++; $display("FAIL dis_pre got=%b%b%b exp=111", s_rise[3], s_clk[4], s_valid[4]); end
    en = 1'b0;
    @(negedge clk);
    checks++; if ({cs, pol, valid, glitch, stall} !== 8'h00) begin errors++;
      $display("FAIL dis_flags got=%b exp=0", {cs, pol, valid, glitch, stall}); end
    checks++; if ({acc, high, low} !== 24'h0) begin errors++;
      $display("FAIL dis_rates got=%h exp=0", {acc, high, low}); end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | cs.clk | cs.any_edge | (acc != '0);
    end
    checks++; if (seen !== 1'b0) begin errors++;
      $display("FAIL dis_idle got=%b exp=0", seen); end
    en = 1'b1;
    @(negedge clk);
    checks++; if (cs.clk !== 1'b1 || cs.rise !== 1'b0 || cs.any_edge !== 1'b0) begin errors++;
      $display("FAIL reen_level got=%b%b%b exp=100", cs.clk, cs.rise, cs.any_edge); end
    @(negedge clk);
    checks++; if (cs.rise !== 1'b0 || acc !== 8'd1 || valid !== 1'b0) begin errors++;
      $display("FAIL reen_quiet got=%b/%0d/%b exp=0/1/0", cs.rise, acc, valid); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_glitch();
    test_stall();
    test_rearm();
    test_saturation();
    test_disable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
